// File: rtl/mp_add_sequencer_pkg.sv
// Shared constants for the multi-precision add sequencer: word width,
// FSM encodings and the word-index width helper.
package mp_add_sequencer_pkg;

    localparam int unsigned WORD_W = 64;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/carry_skip_adder_64bit.sv
// 64-bit carry-skip adder: eight 8-bit ripple blocks, each bypassed when
// every bit in the block propagates.
module carry_skip_adder_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);

    logic [7:0][7:0] av;
    logic [7:0][7:0] bv;
    logic [7:0][7:0] sv;

    assign av  = a;
    assign bv  = b;
    assign sum = sv;

    always_comb begin
        logic       c;
        logic [8:0] rs;
        logic       p;
        c  = cin;
        rs = '0;
        p  = 1'b0;
        sv = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            rs = {1'b0, av[k[2:0]]} + {1'b0, bv[k[2:0]]} + {8'd0, c};
            p  = &(av[k[2:0]] ^ bv[k[2:0]]);
            sv[k[2:0]] = rs[7:0];
            // A fully propagating block passes its carry-in straight through.
            c = p ? c : rs[8];
        end
        cout = c;
    end

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract: streams WORDS 64-bit words LSW-first through
// one shared 64-bit adder, chaining the carry through a register.
module mp_add_sequencer
    import mp_add_sequencer_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_W*WORDS-1:0]   in_a,
    input  logic [WORD_W*WORDS-1:0]   in_b,
    input  logic                      in_sub,
    input  logic                      in_cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_W*WORDS-1:0]   out_sum,
    output logic                      out_cout,
    output logic                      out_zero
);

    localparam int unsigned      IDX_W    = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    logic [1:0]                   state;
    logic [WORDS-1:0][WORD_W-1:0] a_r;
    logic [WORDS-1:0][WORD_W-1:0] b_r;
    logic [WORDS-1:0][WORD_W-1:0] sum_r;
    logic                         sub_r;
    logic                         carry;
    logic [IDX_W-1:0]             idx;
    logic [WORD_W-1:0]            add_sum;
    logic                         add_cout;

    carry_skip_adder_64bit u_adder (
        .a    (a_r[idx]),
        .b    (b_r[idx] ^ {WORD_W{sub_r}}),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            a_r   <= '0;
            b_r   <= '0;
            sum_r <= '0;
            sub_r <= 1'b0;
            carry <= 1'b0;
            idx   <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r   <= in_a;
                        b_r   <= in_b;
                        sub_r <= in_sub;
                        // Subtract is A + ~B + 1, so the request carry only matters for add.
                        carry <= in_sub | in_cin;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_r[idx] <= add_sum;
                    carry      <= add_cout;
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign out_sum   = sum_r;
    // The carry register holds the final carry while DONE; nothing else writes it there.
    assign out_cout  = carry;
    assign out_zero  = out_valid & ~|sum_r;

endmodule
